// File: rtl/pixel_streamer_if.sv
// Byte-in / pixel-out bundle shared by the pixel streamer and whatever
// feeds it bytes and requests pixels. The slave modport is the streamer
// side; master is the source/plotter side.
interface pixel_streamer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          pixel_req;
  logic          pixel_valid;
  logic          pixel_bit;
  logic          line_end;
  logic          frame_done;
  logic          underrun;
  logic [6:0]    col;
  logic [6:0]    row;
  logic [CW-1:0] fifo_count;

  modport master (
    output byte_in, byte_valid, pixel_req,
    input  byte_ready, pixel_valid, pixel_bit, line_end, frame_done,
           underrun, col, row, fifo_count
  );

  modport slave (
    input  byte_in, byte_valid, pixel_req,
    output byte_ready, pixel_valid, pixel_bit, line_end, frame_done,
           underrun, col, row, fifo_count
  );
endinterface

// File: rtl/pixel_streamer.sv
// Pixel streamer: buffers packed image bytes in a small FIFO and hands
// them out one pixel at a time to the stepper plotter, tracking the
// column/row position and flagging line end and frame completion.
// Build option: define PIXEL_LSB_FIRST_EN to emit byte bit 0 first;
// otherwise bit 7 is emitted first.
module pixel_streamer #(
  parameter int FIFO_DEPTH = 16,
  parameter int H_PIXELS   = 80,
  parameter int V_PIXELS   = 106
) (
  input  logic         clk_100mhz,
  input  logic         rst,
  pixel_streamer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [6:0]    COL_LAST = 7'(H_PIXELS - 1);
  localparam logic [6:0]    ROW_LAST = 7'(V_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_rd_data;
  logic          push;
  logic          pop;
  logic          byte_ready_w;

  // Unpacker / position state
  state_t        state_q;
  logic [7:0]    shreg_q;
  logic [7:0]    shreg_shifted;
  logic [2:0]    bit_idx_q;
  logic          pixel_valid_q;
  logic          line_end_q;
  logic          frame_done_q;
  logic          underrun_q;
  logic [6:0]    col_q;
  logic [6:0]    row_q;
  logic          last_pixel;
  logic          cur_bit;

  // Ready depends only on registered state, so it never combinationally
  // follows byte_valid or pixel_req.
  assign byte_ready_w = (count_q != CNT_FULL) && !frame_done_q;
  assign push         = bus.byte_valid && byte_ready_w;
  assign fifo_rd_data = mem_q[rd_ptr_q];
  assign last_pixel   = (row_q == ROW_LAST) && (col_q == COL_LAST);

`ifdef PIXEL_LSB_FIRST_EN
  assign cur_bit       = shreg_q[0];
  assign shreg_shifted = {1'b0, shreg_q[7:1]};
`else
  assign cur_bit       = shreg_q[7];
  assign shreg_shifted = {shreg_q[6:0], 1'b0};
`endif

  // Pop whenever the unpacker needs a fresh byte: from IDLE as soon as data
  // exists, or on the request that consumes bit 7 so the next byte follows
  // without a bubble. The final pixel of the frame never pops.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = (count_q != '0);
      SHIFT:   pop = bus.pixel_req && (bit_idx_q == 3'd7) && (count_q != '0) && !last_pixel;
      default: pop = 1'b0;
    endcase
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally at AW bits
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO data array; contents need no reset because occupancy is reset
  always_ff @(posedge clk_100mhz) begin
    if (push) mem_q[wr_ptr_q] <= bus.byte_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Unpacker FSM with position tracking and registered status outputs
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      pixel_valid_q <= 1'b0;
      line_end_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
    end else begin
      line_end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.pixel_req) underrun_q <= 1'b1;
          if (count_q != '0) begin
            shreg_q       <= fifo_rd_data;
            bit_idx_q     <= '0;
            pixel_valid_q <= 1'b1;
            state_q       <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.pixel_req) begin
            if (last_pixel) begin
              // Counters keep their final values once the frame completes
              line_end_q    <= 1'b1;
              frame_done_q  <= 1'b1;
              pixel_valid_q <= 1'b0;
              state_q       <= DONE;
            end else begin
              if (col_q == COL_LAST) begin
                col_q      <= '0;
                row_q      <= row_q + 7'd1;
                line_end_q <= 1'b1;
              end else begin
                col_q <= col_q + 7'd1;
              end
              if (bit_idx_q != 3'd7) begin
                shreg_q   <= shreg_shifted;
                bit_idx_q <= bit_idx_q + 3'd1;
              end else if (count_q != '0) begin
                shreg_q   <= fifo_rd_data;
                bit_idx_q <= '0;
              end else begin
                pixel_valid_q <= 1'b0;
                state_q       <= IDLE;
              end
            end
          end
        end
        DONE: begin
          if (bus.pixel_req) underrun_q <= 1'b1;
        end
        default: begin
          pixel_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready  = byte_ready_w;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_bit   = pixel_valid_q ? cur_bit : 1'b0;
  assign bus.line_end    = line_end_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.underrun    = underrun_q;
  assign bus.col         = col_q;
  assign bus.row         = row_q;
  assign bus.fifo_count  = count_q;
endmodule
